instr_decode_unit: RTL

Holds the architectural PC, the previous-PC register and the instruction register of the multicycle RV32I core, and decodes the latched instruction into the fields and control codes consumed by the control unit. It sits directly upstream of the control unit. It captures memory read port 1 on `instr_reg_WE` and presents `opcode/rs1/rs2/rd` combinationally from the instruction register. It presents `ALU_control_dec/imm_control_dec/store_control_dec` registered one cycle later, in time for every execute state.

---
 rtl/instr_decode_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_decode_unit.sv
// PC, previous-PC and instruction registers of the multicycle RV32I core, plus the
// registered decode of the latched instruction. Optional illegal-encoding detection: DECODE_ILLEGAL_EN.
module instr_decode_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ALU_CTRL_W   = 5,
  parameter int          IMM_CTRL_W   = 3,
  parameter int          STORE_CTRL_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             mem_R1,
  input  logic [31:0]             ALU_out,
  input  logic                    pc_WE,
  input  logic                    old_pc_reg_WE,
  input  logic                    instr_reg_WE,
  output logic [31:0]             pc,
  output logic [31:0]             old_pc,
  output logic [6:0]              opcode,
  output logic [4:0]              rs1,
  output logic [4:0]              rs2,
  output logic [4:0]              rd,
  output logic [ALU_CTRL_W-1:0]   ALU_control_dec,
  output logic [IMM_CTRL_W-1:0]   imm_control_dec,
  output logic [STORE_CTRL_W-1:0] store_control_dec,
  output logic                    dec_valid,
  output logic                    illegal,
  output logic [31:0]             instr_count
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_BEQ  = 5'd10, ALU_BNE  = 5'd11,
    ALU_BLT  = 5'd12, ALU_BGE  = 5'd13, ALU_BLTU = 5'd14, ALU_BGEU = 5'd15,
    ALU_PASS_B = 5'd16,
    ALU_LB   = 5'd17, ALU_LH   = 5'd18, ALU_LW   = 5'd19, ALU_LBU  = 5'd20,
    ALU_LHU  = 5'd21
  } alu_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4, IMM_SHAMT = 3'd5
  } imm_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  F7_ZERO   = 7'b0000000;
  localparam logic [6:0]  F7_ALT    = 7'b0100000;

`ifdef DECODE_ILLEGAL_EN
  localparam bit ILLEGAL_EN = 1'b1;
`else
  localparam bit ILLEGAL_EN = 1'b0;
`endif

  logic [31:0]             pc_q, old_pc_q, ir_q, instr_count_q;
  logic [ALU_CTRL_W-1:0]   alu_q;
  logic [IMM_CTRL_W-1:0]   imm_q;
  logic [STORE_CTRL_W-1:0] store_q;
  logic                    dec_valid_q, illegal_q;

  alu_e       alu_d;
  imm_e       imm_d;
  logic [3:0] store_d;
  logic       bad_enc;
  logic       illegal_d;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_alu_lsb;

  // The PC is always halfword-aligned; the jalr target bit 0 is dropped here.
  assign unused_alu_lsb = ALU_out[0];

  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    alu_d   = ALU_ADD;
    imm_d   = IMM_I;
    store_d = 4'b0000;
    bad_enc = 1'b0;
    case (ir_q[6:0])
      OP_R: begin
        case (funct3)
          3'd0: alu_d = funct7[5] ? ALU_SUB : ALU_ADD;
          3'd1: alu_d = ALU_SLL;
          3'd2: alu_d = ALU_SLT;
          3'd3: alu_d = ALU_SLTU;
          3'd4: alu_d = ALU_XOR;
          3'd5: alu_d = funct7[5] ? ALU_SRA : ALU_SRL;
          3'd6: alu_d = ALU_OR;
          default: alu_d = ALU_AND;
        endcase
        bad_enc = !((funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
      OP_IMM: begin
        case (funct3)
          3'd0: alu_d = ALU_ADD;
          3'd1: begin
            alu_d   = ALU_SLL;
            imm_d   = IMM_SHAMT;
            bad_enc = (funct7 != F7_ZERO);
          end
          3'd2: alu_d = ALU_SLT;
          3'd3: alu_d = ALU_SLTU;
          3'd4: alu_d = ALU_XOR;
          3'd5: begin
            alu_d   = funct7[5] ? ALU_SRA : ALU_SRL;
            imm_d   = IMM_SHAMT;
            bad_enc = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
          end
          3'd6: alu_d = ALU_OR;
          default: alu_d = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        case (funct3)
          3'd0: alu_d = ALU_LB;
          3'd1: alu_d = ALU_LH;
          3'd2: alu_d = ALU_LW;
          3'd4: alu_d = ALU_LBU;
          3'd5: alu_d = ALU_LHU;
          default: bad_enc = 1'b1;
        endcase
      end
      OP_STORE: begin
        imm_d = IMM_S;
        case (funct3)
          3'd0: store_d = 4'b0001;
          3'd1: store_d = 4'b0011;
          3'd2: store_d = 4'b1111;
          default: bad_enc = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        imm_d = IMM_B;
        case (funct3)
          3'd0: alu_d = ALU_BEQ;
          3'd1: alu_d = ALU_BNE;
          3'd4: alu_d = ALU_BLT;
          3'd5: alu_d = ALU_BGE;
          3'd6: alu_d = ALU_BLTU;
          3'd7: alu_d = ALU_BGEU;
          default: bad_enc = 1'b1;
        endcase
      end
      OP_LUI: begin
        alu_d = ALU_PASS_B;
        imm_d = IMM_U;
      end
      OP_AUIPC: imm_d = IMM_U;
      OP_JAL:   imm_d = IMM_J;
      OP_JALR:  bad_enc = (funct3 != 3'd0);
      default:  bad_enc = 1'b1;
    endcase

    illegal_d = ILLEGAL_EN && bad_enc;
    if (illegal_d) begin
      alu_d   = ALU_ADD;
      imm_d   = IMM_I;
      store_d = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      old_pc_q      <= '0;
      ir_q          <= NOP_INSTR;
      instr_count_q <= '0;
      alu_q         <= '0;
      imm_q         <= '0;
      store_q       <= '0;
      dec_valid_q   <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      if (pc_WE) pc_q <= {ALU_out[31:1], 1'b0};
      // NOTE: non-blocking assignment makes old_pc capture the pre-update PC when both enables fire.
      if (old_pc_reg_WE) old_pc_q <= pc_q;
      if (instr_reg_WE) begin
        ir_q          <= mem_R1;
        instr_count_q <= instr_count_q + 32'd1;
      end
      // Decode of the IR currently held; it matches only if the IR is not being rewritten.
      alu_q       <= ALU_CTRL_W'(alu_d);
      imm_q       <= IMM_CTRL_W'(imm_d);
      store_q     <= STORE_CTRL_W'(store_d);
      illegal_q   <= illegal_d;
      dec_valid_q <= !instr_reg_WE;
    end
  end

  assign pc                = pc_q;
  assign old_pc            = old_pc_q;
  assign opcode            = ir_q[6:0];
  assign rd                = ir_q[11:7];
  assign rs1               = ir_q[19:15];
  assign rs2               = ir_q[24:20];
  assign ALU_control_dec   = alu_q;
  assign imm_control_dec   = imm_q;
  assign store_control_dec = store_q;
  assign dec_valid         = dec_valid_q;
  assign illegal           = illegal_q;
  assign instr_count       = instr_count_q;

endmodule
